// File: rtl/div_unit_pkg.sv
// Shared definitions for the RV32M iterative divider: width, func3 encodings, FSM states.
package div_unit_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] DIV_F3  = 3'b100;
  localparam logic [2:0] DIVU_F3 = 3'b101;
  localparam logic [2:0] REM_F3  = 3'b110;
  localparam logic [2:0] REMU_F3 = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division step: shift in the next dividend bit, subtract if it fits.
module div_step
  import div_unit_pkg::*;
(
  input  logic [XLEN-1:0] rem,
  input  logic            dvd_msb,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] next_rem,
  output logic            q_bit
);

  // The shifted partial remainder needs XLEN+1 bits when the divisor exceeds 2^(XLEN-1).
  logic [XLEN:0] rem_shift;

  assign rem_shift = {rem, dvd_msb};
  assign q_bit     = (rem_shift >= {1'b0, divisor});
  assign next_rem  = q_bit ? (rem_shift[XLEN-1:0] - divisor) : rem_shift[XLEN-1:0];

endmodule

// File: rtl/div_unit.sv
// Iterative RV32M DIV/DIVU/REM/REMU unit, one quotient bit per cycle, with busy/valid handshake.
module div_unit
  import div_unit_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            busy,
  output logic            valid,
  output logic [XLEN-1:0] result
);

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  state_t          state, state_nx;
  logic [4:0]      count;
  logic [XLEN-1:0] rem, dvd, dvs;
  logic            is_rem, neg_q, neg_r;

  logic signed [XLEN-1:0] a_s, b_s;
  logic            is_signed, a_neg, b_neg, b_zero, ovf, special, accept;
  logic [XLEN-1:0] abs_a, abs_b, special_res;
  logic [XLEN-1:0] step_rem;
  logic            step_q;
  logic [XLEN-1:0] quot_nx;

  function automatic logic [XLEN-1:0] apply_sign(input logic [XLEN-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  assign a_s       = op_a;
  assign b_s       = op_b;
  assign is_signed = ~func3[0];
  assign a_neg     = is_signed && (a_s < 0);
  assign b_neg     = is_signed && (b_s < 0);
  assign b_zero    = (op_b == '0);
  assign ovf       = is_signed && (op_a == INT_MIN) && (op_b == '1);
  assign special   = b_zero || ovf;
  // -INT_MIN wraps to INT_MIN, which is still the correct unsigned magnitude.
  assign abs_a     = a_neg ? -op_a : op_a;
  assign abs_b     = b_neg ? -op_b : op_b;

  always_comb begin
    special_res = '0;
    if (b_zero)
      special_res = func3[1] ? op_a : '1;
    else
      special_res = func3[1] ? '0 : INT_MIN;
  end

  assign accept = start && func3[2] && !flush && (state != RUN);

  div_step u_step (
    .rem      (rem),
    .dvd_msb  (dvd[XLEN-1]),
    .divisor  (dvs),
    .next_rem (step_rem),
    .q_bit    (step_q)
  );

  // The dividend register doubles as the quotient: each step shifts a quotient bit into the LSB.
  assign quot_nx = {dvd[XLEN-2:0], step_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (flush) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) state_nx = special ? DONE : RUN;
          else        state_nx = IDLE;
        end
        RUN: begin
          if (count == 5'd31) state_nx = DONE;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= '0;
      rem    <= '0;
      dvd    <= '0;
      dvs    <= '0;
      is_rem <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      result <= '0;
    end else if (accept) begin
      count  <= '0;
      rem    <= '0;
      dvd    <= abs_a;
      dvs    <= abs_b;
      is_rem <= func3[1];
      neg_q  <= (a_neg ^ b_neg) && !b_zero;
      neg_r  <= a_neg;
      if (special) result <= special_res;
    end else if (state == RUN && !flush) begin
      count <= count + 5'd1;
      rem   <= step_rem;
      dvd   <= quot_nx;
      if (count == 5'd31)
        result <= is_rem ? apply_sign(step_rem, neg_r) : apply_sign(quot_nx, neg_q);
    end
  end

  assign busy  = (state == RUN);
  assign valid = (state == DONE);

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: stimulus pushes model results, a negedge monitor pops on valid.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  func3 = 3'b000;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        flush = 1'b0;
  logic        busy, valid;
  logic [31:0] result;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_res = '0;

  div_unit dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .func3  (func3),
    .op_a   (op_a),
    .op_b   (op_b),
    .flush  (flush),
    .busy   (busy),
    .valid  (valid),
    .result (result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: RISC-V M-extension semantics from plain integer arithmetic.
  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic sgn, want_rem;
    sgn      = !f3[0];
    want_rem = f3[1];
    if (b == 32'd0) return want_rem ? a : 32'hFFFF_FFFF;
    if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return want_rem ? 32'd0 : 32'h8000_0000;
    if (sgn) return want_rem ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
    return want_rem ? a % b : a / b;
  endfunction

  initial begin : monitor
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_valid", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("result", result, e);
        end
      end
    end
  end

  // Drives an op starting now; returns at the negedge of the completion cycle (DONE).
  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input string name);
    int lat, bcnt;
    bit special;
    special = (b == 32'd0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    last_res = model(f3, a, b);
    exp_q.push_back(last_res);
    func3 = f3; op_a = a; op_b = b; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    lat = 0; bcnt = 0;
    while (lat < 100) begin
      @(negedge clk);
      lat++;
      if (busy) bcnt++;
      if (valid) break;
    end
    chk({name, "_lat"},  32'(lat),  special ? 32'd1 : 32'd33);
    chk({name, "_busy"}, 32'(bcnt), special ? 32'd0 : 32'd32);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_op();
    int sel;
    sel = $urandom_range(0, 7);
    case (sel)
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(1, 20));
      4: return 32'h8000_0000 | 32'($urandom_range(0, 255));
      default: return $urandom;
    endcase
  endfunction

  initial begin : stim
    int vcnt;
    logic [1:0] lo;
    logic [31:0] ra, rb;

    #2;
    chk("rst_busy",   {31'd0, busy},  32'd0);
    chk("rst_valid",  {31'd0, valid}, 32'd0);
    chk("rst_result", result,         32'd0);
    idle(2);
    rst_n = 1'b1;
    idle(1);

    issue(3'b101, 32'd100, 32'd7, "divu_100_7");
    idle(1);
    issue(3'b111, 32'd100, 32'd7, "remu_100_7");
    idle(1);
    issue(3'b100, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
    issue(3'b110, 32'hFFFF_FFF9, 32'd2, "rem_m7_2");
    issue(3'b110, 32'd7, 32'hFFFF_FFFE, "rem_7_m2");
    idle(1);
    issue(3'b100, 32'd5, 32'd0, "div_5_0");
    issue(3'b111, 32'd5, 32'd0, "remu_5_0");
    issue(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    issue(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf");
    issue(3'b101, 32'hFFFF_FFFF, 32'h8000_0001, "divu_bigdvs");
    idle(2);

    // func3[2]=0 is not a divide and must be ignored.
    func3 = 3'b001; op_a = 32'd9; op_b = 32'd3; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk("nondiv_busy", {31'd0, busy}, 32'd0);
    idle(2);

    // Flush in cycle 10 kills the op; the result register must keep the previous value.
    func3 = 3'b101; op_a = 32'd100; op_b = 32'd7; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    chk("flush_busy", {31'd0, busy}, 32'd0);
    vcnt = 0;
    repeat (40) begin @(negedge clk); if (valid) vcnt++; end
    chk("flush_novalid", 32'(vcnt), 32'd0);
    chk("flush_hold", result, last_res);
    idle(1);
    issue(3'b101, 32'd20, 32'd3, "divu_20_3");

    // Start coinciding with flush is dropped.
    idle(1);
    func3 = 3'b101; op_a = 32'd50; op_b = 32'd5; start = 1'b1; flush = 1'b1;
    @(posedge clk); #1 start = 1'b0; flush = 1'b0;
    chk("flushstart_busy", {31'd0, busy}, 32'd0);
    idle(3);

    // Back-to-back: the second start lands in the first op's DONE cycle.
    issue(3'b101, 32'd1000, 32'd10, "b2b_first");
    issue(3'b101, 32'd9, 32'd3, "b2b_second");
    idle(2);

    // Asynchronous reset during RUN.
    func3 = 3'b101; op_a = 32'd100; op_b = 32'd7; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_busy",   {31'd0, busy},  32'd0);
    chk("arst_valid",  {31'd0, valid}, 32'd0);
    chk("arst_result", result,         32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    vcnt = 0;
    repeat (40) begin @(negedge clk); if (valid) vcnt++; end
    chk("arst_novalid", 32'(vcnt), 32'd0);
    idle(1);
    issue(3'b100, 32'hFFFF_FF9C, 32'd7, "post_rst_div");
    idle(1);

    for (int i = 0; i < 120; i++) begin
      lo = 2'($urandom_range(0, 3));
      ra = rand_op();
      rb = rand_op();
      issue({1'b1, lo}, ra, rb, "rand");
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    idle(3);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
